// File: rtl/multiplier_arbiter_if.sv
// Requester, response and multiplier-side signals of multiplier_arbiter.
interface multiplier_arbiter_if #(
  parameter int WIDTH1  = 4,
  parameter int WIDTH2  = 4,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][WIDTH1-1:0] req_in1;
  logic [NUM_REQ-1:0][WIDTH2-1:0] req_in2;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [NUM_REQ-1:0]             resp_ready;
  logic [WIDTH1+WIDTH2-1:0]       resp_out;
  logic                           mul_en;
  logic [WIDTH1-1:0]              mul_in1;
  logic [WIDTH2-1:0]              mul_in2;
  logic [WIDTH1+WIDTH2-1:0]       mul_out;

  modport master (
    input  req_valid, req_in1, req_in2,
    input  resp_ready, mul_out,
    output req_ready, resp_valid, resp_out,
    output mul_en, mul_in1, mul_in2
  );

  modport slave (
    output req_valid, req_in1, req_in2,
    output resp_ready, mul_out,
    input  req_ready, resp_valid, resp_out,
    input  mul_en, mul_in1, mul_in2
  );
endinterface

// File: rtl/multiplier_arbiter.sv
// Round-robin sharing of one pipelined multiplier between NUM_REQ clients.
module multiplier_arbiter #(
  parameter int WIDTH1  = 4,
  parameter int WIDTH2  = 4,
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  multiplier_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);

  logic [LATENCY-1:0]         tag_v;
  logic [LATENCY-1:0][IW-1:0] tag_id;
  logic [IW-1:0]              rr_ptr;
  logic [IW-1:0]              gnt;
  logic [IW-1:0]              sel;
  logic [IW-1:0]              tail_id;
  logic                       tail_v;
  logic                       any;
  logic                       stall;
  logic                       adv;
  logic                       fire;
  int                         idx;

  assign tail_v  = tag_v[LATENCY-1];
  assign tail_id = tag_id[LATENCY-1];
  assign stall   = tail_v && !bus.resp_ready[tail_id];
  assign adv     = en && !rst && !stall;
  assign fire    = adv && any;

  // Scan downward so the requester nearest rr_ptr wins.
  always_comb begin
    gnt = rr_ptr;
    any = 1'b0;
    idx = 0;
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IW'(idx);
      if (bus.req_valid[sel]) begin
        gnt = sel;
        any = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.req_ready[gnt] = adv;
    bus.resp_valid[tail_id] = tail_v && en && !rst;
  end

  // The multiplier keeps running through reset so its own pipe clears.
  assign bus.mul_en   = rst || adv;
  assign bus.mul_in1  = fire ? bus.req_in1[gnt] : '0;
  assign bus.mul_in2  = fire ? bus.req_in2[gnt] : '0;
  assign bus.resp_out = bus.mul_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
      rr_ptr <= '0;
    end else if (adv) begin
      tag_v[0]  <= fire;
      tag_id[0] <= gnt;
      for (int s = 1; s < LATENCY; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      if (fire) begin
        if (gnt == IW'(NUM_REQ - 1)) rr_ptr <= '0;
        else rr_ptr <= gnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed and random checks of multiplier_arbiter against a queue model.
module tb_multiplier_arbiter;
  localparam int W1  = 4;
  localparam int W2  = 4;
  localparam int NR  = 2;
  localparam int LAT = 4;
  localparam int WO  = W1 + W2;

  typedef struct { int a; int b; } op_t;
  typedef struct { int id; int prod; int age; } item_t;
  typedef struct { int id; int val; int cyc; } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  multiplier_arbiter_if #(.WIDTH1(W1), .WIDTH2(W2), .NUM_REQ(NR)) bus ();

  multiplier_arbiter #(
    .WIDTH1(W1), .WIDTH2(W2), .NUM_REQ(NR), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus.master)
  );

  // Attached multiplier: LAT enabled stages, cleared by its own reset.
  logic [WO-1:0] mpipe [LAT];
  always @(posedge clk) begin
    if (bus.mul_en) begin
      if (rst) begin
        for (int s = 0; s < LAT; s++) mpipe[s] <= '0;
      end else begin
        mpipe[0] <= WO'(bus.mul_in1) * WO'(bus.mul_in2);
        for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
      end
    end
  end
  assign bus.mul_out = mpipe[LAT-1];

  op_t   reqq [NR][$];
  item_t fl[$];
  ev_t   gq[$];
  ev_t   rq[$];
  int    ptr;
  int    cyc;
  int    n_chk;
  int    n_fail;
  int    stalls;
  logic  seen_en;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int  g;
    bit  any;
    bit  tail;
    bit  stall;
    bit  adv;
    bit  fire;
    int  e_rr;
    int  e_rv;
    int  ea;
    int  eb;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = reqq[i].size() > 0;
      bus.req_in1[i] = reqq[i].size() > 0 ? W1'(reqq[i][0].a) : '0;
      bus.req_in2[i] = reqq[i].size() > 0 ? W2'(reqq[i][0].b) : '0;
    end
    #1;
    tail  = fl.size() > 0 && fl[0].age == LAT;
    stall = tail && !bus.resp_ready[fl[0].id];
    adv   = en && !rst && !stall;
    any = 0;
    g = ptr;
    for (int k = 0; k < NR; k++) begin
      if (!any && reqq[(ptr + k) % NR].size() > 0) begin
        any = 1;
        g = (ptr + k) % NR;
      end
    end
    fire = adv && any;
    e_rr = adv ? (1 << g) : 0;
    e_rv = (tail && en && !rst) ? (1 << fl[0].id) : 0;
    ea = fire ? reqq[g][0].a : 0;
    eb = fire ? reqq[g][0].b : 0;
    chk("req_ready", 32'(bus.req_ready), e_rr);
    chk("resp_valid", 32'(bus.resp_valid), e_rv);
    chk("mul_en", 32'(bus.mul_en), 32'(rst || adv));
    if (tail && !rst) chk("resp_out", 32'(bus.resp_out), fl[0].prod);
    if (adv || rst) begin
      chk("mul_in1", 32'(bus.mul_in1), ea);
      chk("mul_in2", 32'(bus.mul_in2), eb);
    end
    seen_en = bus.mul_en;
    for (int i = 0; i < NR; i++) begin
      if (bus.req_ready[i] && bus.req_valid[i])
        gq.push_back('{i, 0, cyc});
      if (bus.resp_valid[i] && bus.resp_ready[i])
        rq.push_back('{i, int'(bus.resp_out), cyc});
    end
    @(posedge clk);
    if (rst) begin
      fl.delete();
      ptr = 0;
    end else if (adv) begin
      if (tail) void'(fl.pop_front());
      foreach (fl[i]) fl[i].age++;
      if (fire) begin
        fl.push_back('{g, ea * eb, 1});
        void'(reqq[g].pop_front());
        ptr = (g + 1) % NR;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr();
    gq.delete();
    rq.delete();
  endtask

  int fair_id [6] = '{0, 1, 0, 1, 0, 1};
  int fair_p  [6] = '{225, 0, 6, 16, 49, 15};
  int bp_p    [3] = '{42, 15, 2};

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    ptr = 0;
    rst = 1'b1;
    en = 1'b1;
    bus.resp_ready = '1;
    bus.req_valid = '0;
    bus.req_in1 = '0;
    bus.req_in2 = '0;
    @(negedge clk);
    run(LAT + 1);
    rst = 1'b0;

    // single request
    clr();
    reqq[0].push_back('{13, 11});
    run(8);
    chk("single_grants", gq.size(), 1);
    chk("single_resps", rq.size(), 1);
    if (rq.size() == 1 && gq.size() == 1) begin
      chk("single_prod", rq[0].val, 143);
      chk("single_lat", rq[0].cyc - gq[0].cyc, 4);
      chk("single_id", rq[0].id, 0);
    end

    // fairness from a fresh pointer
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    clr();
    reqq[0].push_back('{15, 15});
    reqq[1].push_back('{0, 9});
    reqq[0].push_back('{2, 3});
    reqq[1].push_back('{4, 4});
    reqq[0].push_back('{7, 7});
    reqq[1].push_back('{1, 15});
    run(12);
    chk("fair_grants", gq.size(), 6);
    chk("fair_resps", rq.size(), 6);
    for (int i = 0; i < 6 && i < gq.size() && i < rq.size(); i++) begin
      chk("fair_gid", gq[i].id, fair_id[i]);
      chk("fair_rid", rq[i].id, fair_id[i]);
      chk("fair_prod", rq[i].val, fair_p[i]);
      chk("fair_lat", rq[i].cyc - gq[i].cyc, 4);
    end

    // backpressure on requester 1
    clr();
    bus.resp_ready = 2'b01;
    reqq[0].push_back('{6, 7});
    reqq[1].push_back('{3, 5});
    reqq[0].push_back('{1, 2});
    run(5);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (seen_en === 1'b0) stalls++;
    end
    chk("bp_stalls", stalls, 3);
    bus.resp_ready = 2'b11;
    run(6);
    chk("bp_resps", rq.size(), 3);
    for (int i = 0; i < 3 && i < rq.size(); i++)
      chk("bp_prod", rq[i].val, bp_p[i]);

    // enable low mid-stream
    clr();
    reqq[0].push_back('{9, 9});
    run(2);
    en = 1'b0;
    run(2);
    en = 1'b1;
    run(6);
    chk("en_resps", rq.size(), 1);
    if (rq.size() == 1 && gq.size() == 1) begin
      chk("en_prod", rq[0].val, 81);
      chk("en_lat", rq[0].cyc - gq[0].cyc, 6);
    end

    // reset with three products in flight
    clr();
    reqq[0].push_back('{5, 5});
    reqq[1].push_back('{7, 7});
    reqq[0].push_back('{6, 6});
    run(3);
    chk("rst_fired", gq.size(), 3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(6);
    chk("rst_no_resp", rq.size(), 0);
    clr();
    reqq[0].push_back('{1, 1});
    reqq[1].push_back('{2, 2});
    run(8);
    chk("rst_grants", gq.size(), 2);
    if (gq.size() == 2) chk("rst_first_gid", gq[0].id, 0);
    chk("rst_resps", rq.size(), 2);
    if (rq.size() == 2) chk("rst_prod", rq[1].val, 4);

    // idle bubbles between requests
    clr();
    for (int k = 0; k < 4; k++) begin
      reqq[k % 2].push_back('{k + 3, k + 5});
      run(2);
    end
    run(6);
    chk("idle_resps", rq.size(), 4);
    for (int i = 0; i < 4 && i < rq.size() && i < gq.size(); i++) begin
      chk("idle_lat", rq[i].cyc - gq[i].cyc, 4);
      chk("idle_prod", rq[i].val, (i + 3) * (i + 5));
    end

    // random traffic, backpressure, enable and reset
    for (int n = 0; n < 400; n++) begin
      en = $urandom_range(0, 9) != 0;
      rst = $urandom_range(0, 99) == 0;
      for (int i = 0; i < NR; i++) begin
        bus.resp_ready[i] = $urandom_range(0, 3) != 0;
        if (reqq[i].size() < 2 && $urandom_range(0, 2) == 0)
          reqq[i].push_back('{int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 15))});
      end
      cycle();
    end
    en = 1'b1;
    rst = 1'b0;
    bus.resp_ready = '1;
    run(20);
    chk("drain_flight", fl.size(), 0);
    chk("drain_req0", reqq[0].size(), 0);
    chk("drain_req1", reqq[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

Shares one pipelined `multiplier` instance between `NUM_REQ` requesters using valid/ready handshakes on the request and response sides. It issues one operand pair per advancing cycle, chosen round-robin among the requesters. A tag pipeline that matches the multiplier's latency records which requester owns each in-flight product. When the owner of the product leaving the pipeline is not ready, the arbiter stalls the whole multiplier through its `en`. It sits between the multiplier and the datapath clients that need it.

## Interface
- `WIDTH1`, default 4: width of operand 1.
- `WIDTH2`, default 4: width of operand 2.
- `NUM_REQ`, default 2: number of requesters; must be ≥ 2.
- `LATENCY`, default 4: pipeline depth of the attached multiplier, counted in enabled cycles; must be ≥ 1.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: global enable. While low, nothing advances, no handshakes fire, and all state is held.
- `req_valid` in `NUM_REQ`: request valid, one bit per requester.
- `req_ready` out `NUM_REQ`: request accepted; at most one bit is high.
- `req_in1` in `[NUM_REQ-1:0][WIDTH1-1:0]`: operand 1 for each requester.
- `req_in2` in `[NUM_REQ-1:0][WIDTH2-1:0]`: operand 2 for each requester.
- `resp_valid` out `NUM_REQ`: result valid for the owning requester; at most one bit is high.
- `resp_ready` in `NUM_REQ`: result accept, one bit per requester.
- `resp_out` out `WIDTH1+WIDTH2`: shared result bus.
- `mul_en` out 1: drives the multiplier's `en`.
- `mul_in1` out `WIDTH1`: drives the multiplier's `in1`.
- `mul_in2` out `WIDTH2`: drives the multiplier's `in2`.
- `mul_out` in `WIDTH1+WIDTH2`: the multiplier's `out`.

## Operation
- **Tag pipeline.** `LATENCY` stages, each holding `{valid, id}`. The tail is stage `LATENCY-1`; it is aligned with `mul_out`.
- **Stall condition.** `stall = tail.valid && !resp_ready[tail.id]`.
- **Advance.** `adv = en && !rst && !stall`.
- **Multiplier enable.** `mul_en = adv`, except while `rst` is high, when `mul_en = 1` so the multiplier's own reset completes.
- **Grant.** Round-robin over `req_valid`, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`. The grant `g` is combinational. `req_ready[g] = adv`.
- **Fire.** A request fires when `req_valid[g] && adv`. On fire:
  - `mul_in1 = req_in1[g]` and `mul_in2 = req_in2[g]`.
  - Tag stage 0 loads `{1, g}`.
  - `rr_ptr` becomes `(g+1) mod NUM_REQ`.
- **Bubble.** If `adv` is high and no request is valid, a bubble is issued: `mul_in1/2 = 0`, stage 0 loads `valid = 0`, and `rr_ptr` is unchanged.
- **Shift.** The tag stages shift only on `adv`. When `adv` is low, tags, `rr_ptr` and the multiplier all hold, so alignment is preserved.
- **Response outputs.**
  - `resp_valid[tail.id] = tail.valid && en && !rst`.
  - `resp_out = mul_out` (combinational pass-through).
- **Retire.** A response retires when `resp_valid && resp_ready` are both high for the owner. In that case `stall` is low, so the pipe advances and the tail is replaced in the same cycle.
- **Request stability.** A requester holds `req_in1/2` stable while `req_valid` is high and not yet accepted. The arbiter does not check this.
- **Arithmetic.** `resp_out` is the unsigned `WIDTH1 x WIDTH2` product, full width, with no truncation.

## Timing
- **Reset values** (register state after `rst`): all tag valid bits 0, `rr_ptr = 0`.
- **Outputs while `rst` is high:**
  - `req_ready = 0`, `resp_valid = 0`.
  - `mul_in1/2 = 0`, `mul_en = 1`.
- **Reset mid-operation.** In-flight products are discarded and never reported.
- **Latency.** A request that fires in cycle t gives `resp_valid` in cycle t+`LATENCY`, provided `adv` is high in cycles t+1 … t+`LATENCY`-1. Each cycle in which `adv` is low adds one cycle.
- **Throughput.** One issue per cycle when `resp_ready` is held high, including back-to-back issues from the same requester when it is the only one valid.
- **Backpressure.** `stall` blocks issue in the same cycle: `req_ready` is all zero. No product is ever dropped or duplicated.
- **Independence of response ready.** Results owned by requester A are unaffected by `resp_ready` of other requesters, except through the shared stall (head-of-line blocking is intended).
- **Simultaneous retire and issue.** Both happen in one cycle.
- **Pointer wrap.** `rr_ptr = NUM_REQ-1` wraps to 0.

## Test plan
All scenarios use `NUM_REQ = 2`, `WIDTH1 = WIDTH2 = 4`, `LATENCY = 4`.
- **Single request.** Requester 0 requests 13×11 at cycle 0, with `resp_ready = 1` → `req_ready[0]` in cycle 0; `resp_valid[0]` with `resp_out = 143` in cycle 4; nothing else is valid.
- **Fairness.** Both requesters hold `req_valid` for 6 cycles → grants alternate 0,1,0,1,0,1. Responses appear in cycles 4–9 in the same order with the correct products (e.g. 15×15 = 225, 0×9 = 0).
- **Backpressure.** Requester 1's result (3×5) reaches the tail with `resp_ready[1] = 0` for 3 cycles → `mul_en = 0` and `req_ready = 0` in those cycles; `resp_out` holds 15. When `resp_ready[1]` rises, the result retires once and the following results keep order and values.
- **Enable low.** `en = 0` for 2 cycles mid-stream → no handshake and no state change; latency grows by 2.
- **Reset mid-stream.** `rst` is asserted for 1 cycle with 3 products in flight → no `resp_valid` afterwards, `rr_ptr = 0`; the next simultaneous request is granted to requester 0.
- **Idle bubbles.** Requests spaced 2 cycles apart → bubbles produce no `resp_valid`, and each response arrives exactly 4 cycles after its grant.
